// File: rtl/cache_pkg.sv
// cache_pkg: shared types, geometry constants and address-field helpers for
// the direct-mapped cache controller and its line store.
//   Geometry: 64 lines x 4 words of 32 bits, 16-bit word addresses.
//   Address split: tag[15:8], index[7:2], offset[1:0].
package cache_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 2;
  localparam int TAG_WIDTH  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_WORDS = 1 << OFFSET_W;
  localparam int NUM_LINES  = 1 << INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_REFILL    = 3'd2,
    ST_WRITE_MEM = 3'd3,
    ST_RESPOND   = 3'd4
  } cache_state_e;

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_WIDTH];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: tag, valid and data arrays for the direct-mapped cache.
//   clk, rst_n    clock; async active-low reset clears every valid bit only
//   idx           line index used for the lookup and for all writes
//   rd_valid      valid bit of line idx (combinational)
//   rd_tag        stored tag of line idx (combinational)
//   rd_line       all four data words of line idx (combinational)
//   word_we       write word_data into word word_off of line idx
//   line_we       write line_tag into line idx and mark it valid
// Tag and data contents are not reset; a line is only meaningful once its
// valid bit has been set by a completed refill.
module cache_line_store
  import cache_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INDEX_W-1:0]                  idx,
  output logic                                rd_valid,
  output logic [TAG_WIDTH-1:0]                rd_tag,
  output logic [LINE_WORDS-1:0][WORD_W-1:0]   rd_line,
  input  logic                                word_we,
  input  logic [OFFSET_W-1:0]                 word_off,
  input  logic [WORD_W-1:0]                   word_data,
  input  logic                                line_we,
  input  logic [TAG_WIDTH-1:0]                line_tag
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_WIDTH-1:0] tag_mem  [NUM_LINES];
  logic [WORD_W-1:0]    data_mem [NUM_LINES][LINE_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx] <= line_tag;
    end
    if (word_we) begin
      data_mem[idx][word_off] <= word_data;
    end
  end

  always_comb begin
    rd_valid = valid_q[idx];
    rd_tag   = tag_mem[idx];
    for (int w = 0; w < LINE_WORDS; w++) begin
      rd_line[w] = data_mem[idx][w];
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller between one CPU requester and a 32-bit x 64K-word RAM.
//   cpu_req/we/addr/wdata  request, held stable until cpu_ready
//   cpu_rdata              read data, valid while cpu_ready=1, held otherwise
//   cpu_ready              one-cycle completion pulse
//   mem_rd_en/mem_wr_en    RAM strobes (never high together)
//   mem_addr/mem_wdata     RAM address / write data
//   mem_rdata              RAM read data, one cycle after mem_rd_en
//   hit_cnt/miss_cnt       saturating per-access hit/miss counters
//   state_dbg              current FSM state
// Handshake: the requester raises cpu_req with stable fields and keeps them
// until it sees cpu_ready=1 (one cycle); the controller ignores cpu_req in
// that cycle and accepts a new request from the next cycle on.
// Latency from the first IDLE cycle with cpu_req (T0): read hit T2,
// read miss T7, write T3.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,  // must equal cache_pkg::WORD_W
  parameter int ADDR_WIDTH   = 16,  // must equal cache_pkg::ADDR_W
  parameter int INDEX_WIDTH  = 6,   // must equal cache_pkg::INDEX_W
  parameter int OFFSET_WIDTH = 2    // must equal cache_pkg::OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt,
  output cache_state_e          state_dbg
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  cache_state_e state_q, state_d;
  logic [2:0]            k_q;          // refill step 0..4
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [15:0]           hit_q, miss_q;

  logic [TAG_W-1:0]                        req_tag;
  logic [INDEX_WIDTH-1:0]                  req_idx;
  logic [OFFSET_WIDTH-1:0]                 req_off;
  logic                                    line_valid;
  logic [TAG_W-1:0]                        line_tag;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]   line_data;
  logic                                    hit;

  logic                    word_we;
  logic [OFFSET_WIDTH-1:0] word_off;
  logic [DATA_WIDTH-1:0]   word_data;
  logic                    line_we;

  assign req_tag = addr_tag(addr_q);
  assign req_idx = addr_idx(addr_q);
  assign req_off = addr_off(addr_q);
  // The line is not modified between COMPARE and WRITE_MEM, so the same
  // lookup gives the same hit decision in both states.
  assign hit     = line_valid && (line_tag == req_tag);

  cache_line_store u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (req_idx),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .word_we   (word_we),
    .word_off  (word_off),
    .word_data (word_data),
    .line_we   (line_we),
    .line_tag  (req_tag)
  );

  // State register and request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= (state_q == ST_REFILL) ? k_q + 3'd1 : 3'd0;
      if (state_q == ST_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
      end
    end
  end

  // Read data and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      if (state_q == ST_COMPARE) begin
        if (hit) begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end else begin
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
        if (!we_q && hit) rdata_q <= line_data[req_off];
      end
      // Words 0..2 are already in the array at the last refill step; word 3
      // is arriving on mem_rdata in this very cycle.
      if (state_q == ST_REFILL && k_q == 3'd4) begin
        rdata_q <= (req_off == OFFSET_WIDTH'(LINE_WORDS - 1)) ? mem_rdata
                                                              : line_data[req_off];
      end
    end
  end

  // Next state, memory strobes and array writes
  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    word_we   = 1'b0;
    word_off  = '0;
    word_data = '0;
    line_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (we_q)     state_d = ST_WRITE_MEM;
        else if (hit) state_d = ST_RESPOND;
        else          state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (k_q < 3'd4) begin
          mem_rd_en = 1'b1;
          mem_addr  = {req_tag, req_idx, k_q[1:0]};
        end
        // RAM data lags the address by one cycle, so step k stores word k-1.
        if (k_q != 3'd0) begin
          word_we   = 1'b1;
          word_off  = OFFSET_WIDTH'(k_q - 3'd1);
          word_data = mem_rdata;
        end
        if (k_q == 3'd4) begin
          line_we = 1'b1;
          state_d = ST_RESPOND;
        end
      end
      ST_WRITE_MEM: begin
        mem_wr_en = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (hit) begin
          word_we   = 1'b1;
          word_off  = req_off;
          word_data = wdata_q;
        end
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        cpu_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
module tb_dm_cache_ctrl;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] hit_cnt, miss_cnt;
  cache_state_e state_dbg;

  dm_cache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- RAM model (data = address) ----------------
  logic [31:0] ram [0:65535];
  initial for (int i = 0; i < 65536; i++) ram[i] = 32'(i);

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_rd_q[$];
  int          obs_cyc_q[$];
  int          rd_n, wr_n;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata);
    obs_rd_q.delete();
    obs_cyc_q.delete();
    rd_n = 0; wr_n = 0; wr_addr = '0; wr_data = '0;
    lat = 0; rdata = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (mem_rd_en) begin
        rd_n++;
        obs_rd_q.push_back(mem_addr);
        obs_cyc_q.push_back(c);
      end
      if (mem_wr_en) begin
        wr_n++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
      end
      if (cpu_ready) begin
        lat = c;
        rdata = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_hit_cnt"}, {16'b0, hit_cnt}, 32'(exp_hit));
    check({tag, "_miss_cnt"}, {16'b0, miss_cnt}, 32'(exp_miss));
  endtask

  task automatic check_refill(input string tag, input logic [15:0] a);
    logic [15:0] base;
    base = {a[15:2], 2'b00};
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 16'(i));
    check({tag, "_rd_count"}, 32'(rd_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (i < obs_rd_q.size()) begin
        check({tag, "_rd_addr"}, {16'b0, obs_rd_q[i]}, {16'b0, e});
        // reads in consecutive cycles T2..T5
        check({tag, "_rd_cycle"}, 32'(obs_cyc_q[i]), 32'(2 + i));
      end
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp_d, input bit miss);
    int lat;
    logic [31:0] d;
    do_access(1'b0, a, 32'd0, lat, d);
    if (miss) exp_miss++; else exp_hit++;
    check({tag, "_latency"}, 32'(lat), miss ? 32'd7 : 32'd2);
    check({tag, "_rdata"}, d, exp_d);
    if (miss) check_refill(tag, a);
    else check({tag, "_rd_count"}, 32'(rd_n), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_n), 32'd0);
    check_counters(tag);
  endtask

  task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] wd, input bit miss);
    int lat;
    logic [31:0] d;
    do_access(1'b1, a, wd, lat, d);
    if (miss) exp_miss++; else exp_hit++;
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_wr_count"}, 32'(wr_n), 32'd1);
    check({tag, "_wr_addr"}, {16'b0, wr_addr}, {16'b0, a});
    check({tag, "_wr_data"}, wr_data, wd);
    check({tag, "_rd_count"}, 32'(rd_n), 32'd0);
    check_counters(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, {31'b0, cpu_ready}, 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_mem_rd_en"}, {31'b0, mem_rd_en}, 32'd0);
    check({tag, "_mem_wr_en"}, {31'b0, mem_wr_en}, 32'd0);
    check({tag, "_mem_addr"}, {16'b0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_hit_cnt"}, {16'b0, hit_cnt}, 32'd0);
    check({tag, "_miss_cnt"}, {16'b0, miss_cnt}, 32'd0);
    check({tag, "_state"}, {29'b0, state_dbg}, {29'b0, ST_IDLE});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // 1: cold miss, line refilled from 0x0004..0x0007
    rd("t1_rd_0004", 16'h0004, 32'h0000_0004, 1'b1);
    // cpu_rdata holds its value after RESPOND
    @(negedge clk);
    check("t1_rdata_hold", cpu_rdata, 32'h0000_0004);

    // 2: hit in the same line
    rd("t2_rd_0006", 16'h0006, 32'h0000_0006, 1'b0);

    // 3: write hit, then read it back from the cache
    wr("t3_wr_0005", 16'h0005, 32'hDEAD_BEEF, 1'b0);
    rd("t3_rd_0005", 16'h0005, 32'hDEAD_BEEF, 1'b0);

    // 4: conflict on index 1 evicts tag 0, then tag 0 comes back
    rd("t4_rd_0104", 16'h0104, 32'h0000_0104, 1'b1);
    rd("t4_rd_0004", 16'h0004, 32'h0000_0004, 1'b1);
    // write-through: refetched line carries the earlier store
    rd("t4_rd_0005", 16'h0005, 32'hDEAD_BEEF, 1'b0);

    // 5: write miss does not allocate; following read refills from RAM
    wr("t5_wr_2000", 16'h2000, 32'h1234_5678, 1'b1);
    rd("t5_rd_2000", 16'h2000, 32'h1234_5678, 1'b1);

    // requested word at offset 3 comes straight from mem_rdata
    rd("off3_rd_0107", 16'h0107, 32'h0000_0107, 1'b1);
    rd("off3_rd_0106", 16'h0106, 32'h0000_0106, 1'b0);

    // 6: reset during refill step k=2 (cycle T4)
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0304; cpu_wdata = '0;
    repeat (4) @(negedge clk);
    check("t6_pre_rst_rd_en", {31'b0, mem_rd_en}, 32'd1);
    check("t6_pre_rst_addr", {16'b0, mem_addr}, 32'h0000_0306);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_reset_outputs("t6_mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_hit = 0;
    exp_miss = 0;
    rd("t6_rd_0004", 16'h0004, 32'h0000_0004, 1'b1);
    rd("t6_rd_0304", 16'h0304, 32'h0000_0304, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate cache controller between a single CPU-side requester and the 32-bit x 64K-word RAM. It holds tag, valid and data arrays for 64 lines of 4 words each. It sequences RAM reads for 4-word line refills and issues single-word RAM writes for stores. It also keeps saturating hit and miss counters for performance checks.

Parameters:
DATA_WIDTH, 32, word width; must match the RAM.
ADDR_WIDTH, 16, word address width; must match the RAM.
INDEX_WIDTH, 6, line index bits (64 lines).
OFFSET_WIDTH, 2, word-in-line bits (4 words per line).
Derived: TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH (8). Address split is tag[15:8], index[7:2], offset[1:0].

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  request; held high with stable addr, we and wdata until cpu_ready.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_WIDTH  word address.
cpu_wdata  in  DATA_WIDTH  write data.
cpu_rdata  out  DATA_WIDTH  read data; valid while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
mem_rd_en  out  1  RAM read enable; RAM returns data one cycle later.
mem_wr_en  out  1  RAM write enable.
mem_addr  out  ADDR_WIDTH  RAM address.
mem_wdata  out  DATA_WIDTH  RAM write data.
mem_rdata  in  DATA_WIDTH  RAM registered read data.
hit_cnt  out  16  accesses that hit; saturates at 0xFFFF.
miss_cnt  out  16  accesses that missed; saturates at 0xFFFF.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all valid bits=0; refill counter=0.
  - cpu_ready, cpu_rdata, hit_cnt and miss_cnt are 0.
  - mem_rd_en, mem_wr_en, mem_addr and mem_wdata are 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, COMPARE, REFILL, WRITE_MEM, RESPOND.
- IDLE: if cpu_req=1, latch addr, we and wdata, then go to COMPARE.
- COMPARE: hit = valid[idx] && tag[idx]==addr tag. Increment hit_cnt or miss_cnt (saturating) exactly once per access.
  - Read hit: register the data word into cpu_rdata; go to RESPOND.
  - Read miss: go to REFILL.
  - Any write: go to WRITE_MEM.
- REFILL: 5 cycles, counter k=0..4.
  - For k=0..3: mem_rd_en=1, mem_addr={tag,idx,k}.
  - For k=1..4: capture mem_rdata into word k-1.
  - At k=4: set valid[idx]=1, write tag[idx], load cpu_rdata with the requested word (from mem_rdata when the offset is 3); go to RESPOND.
- WRITE_MEM: 1 cycle. mem_wr_en=1, mem_addr=latched addr, mem_wdata=latched wdata.
  - On hit: update the cached word in the same edge.
  - On miss: line state unchanged (no allocate). Go to RESPOND.
- RESPOND: cpu_ready=1 for exactly this cycle; cpu_req is ignored; go to IDLE. The CPU may present the next request from the following cycle.
- Memory outputs are decoded from registered state and counter. They are 0 in every state or cycle not listed above. mem_rd_en and mem_wr_en are never high together.
- Latency, counting the first cycle cpu_req is seen in IDLE as T0, cpu_ready is high at:
  - read hit: T2
  - read miss: T7
  - write (hit or miss): T3
- Reset mid-REFILL abandons the line: valid stays 0 and no partial line is visible afterwards.
- cpu_rdata holds its last value outside RESPOND.

Decomposition:
- Package cache_pkg: state enum, width constants (TAG_WIDTH, LINE_WORDS=4, NUM_LINES=64), and the address-field extraction functions.
- One sub-module, cache_line_store, holding the tag, valid and data arrays.
  - Asynchronous read by index.
  - Synchronous word write and line-tag write.
  - Valid bits cleared by rst_n.

Test Plan:
RAM model is preloaded with data = address.
1. Reset, then read 0x0004 -> miss; mem_rd_en at addresses 0x0004 to 0x0007 in 4 consecutive cycles; cpu_rdata=0x00000004 with cpu_ready at T7; miss_cnt=1.
2. Then read 0x0006 -> hit; cpu_ready at T2 with cpu_rdata=0x00000006; no mem_rd_en; hit_cnt=1.
3. Write 0x0005 with 0xDEADBEEF (hit) -> exactly one mem_wr_en cycle, addr 0x0005, cpu_ready at T3. A following read of 0x0005 hits and returns 0xDEADBEEF.
4. Read 0x0104 (index 1, tag 1) -> miss, refill evicts the line and returns 0x00000104. A following read of 0x0004 misses again and returns 0x00000004.
5. Write miss 0x2000 with 0x12345678 -> single mem write, no refill, miss_cnt increments. A following read of 0x2000 misses and returns 0x12345678.
6. Drop rst_n during REFILL k=2 -> all outputs go to 0 immediately. After release, read 0x0004 misses and refills fully.
